fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 8'd255, WAIT-state cycles before fault; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset: synchronous, active-low.
REQ-005 stage_reset_n  input  1  stage-level abort from the stage controller, active-low.
REQ-006 fetch_start  input  1  single-cycle pulse that starts one fetch at current PC.
REQ-007 wb_if_wren  input  1  single-cycle PC-update strobe.
REQ-008 if_id_wren  input  1  single-cycle strobe that loads the IF/ID outputs.
REQ-009 branch_taken  input  1  selects branch_target for the PC update.
REQ-010 branch_target  input  32  next PC when branch_taken=1.
REQ-011 imem_req  output  1  instruction-memory request.
REQ-012 imem_addr  output  32  request address; equals PC.
REQ-013 imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-014 imem_rdata  input  32  instruction word.
REQ-015 if_id_instr  output  32  latched instruction.
REQ-016 if_id_pc  output  32  PC of the latched instruction.
REQ-017 instr_valid  output  1  a fetched word is buffered (DONE state).
REQ-018 fetch_busy  output  1  high in REQ or WAIT.
REQ-019 fetch_fault  output  1  sticky fault flag.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE.
- IDLE + fetch_start -> REQ.
- REQ drives imem_req=1 and imem_addr=pc. imem_ready=1 -> capture imem_rdata, go to DONE. Otherwise go to WAIT.
- WAIT holds imem_req=1 and imem_addr stable until imem_ready, then captures and goes to DONE.
- DONE: instr_valid=1. if_id_wren -> IDLE.
REQ-021 Latency: pulse at cycle t -> imem_req at t+1. Zero-wait memory -> instr_valid at t+2.
REQ-022 fetch_start outside IDLE is ignored; no state change.
REQ-023 if_id_wren in DONE loads if_id_instr=buffer and if_id_pc=pc.
REQ-024 if_id_wren outside DONE loads if_id_instr=32'h0000_0013 (NOP) and if_id_pc=pc. It does not change FSM state.
REQ-025 wb_if_wren updates PC:
- branch_taken=1 -> pc <= {branch_target[31:2],2'b00}.
- branch_taken=0 -> pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 wb_if_wren while fetch_busy: the PC update still occurs, and imem_addr follows the new pc. The outstanding fetch continues.
REQ-027 stage_reset_n=0 forces FSM to IDLE, deasserts imem_req and clears instr_valid. PC, if_id_* and fetch_fault are retained. It has priority over fetch_start in the same cycle.

Reset
REQ-028 reset_n=0 sets: pc=RESET_PC, FSM=IDLE, imem_req=0, instr_valid=0, fetch_busy=0, fetch_fault=0, if_id_instr=NOP, if_id_pc=RESET_PC.
REQ-029 reset_n has priority over every other input, and reset mid-fetch drops the request in the next cycle.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES: set fetch_fault, buffer NOP, go to DONE.
- Undefined: no counter; WAIT persists indefinitely and fetch_fault stays constant 0.

Structure
REQ-031 Shared package holds: the FSM state enum (fetch_state_t), NOP_INSTR=32'h0000_0013, and the PC increment constant 4.
REQ-032 One sub-module, fetch_pc_reg, holds the PC register and its next-PC mux. The FSM and IF/ID registers stay in fetch_unit.

Verification
REQ-033 Reset then fetch_start with imem_ready=1, imem_rdata=32'h00500093:
- imem_addr=0 at t+1; instr_valid at t+2.
- if_id_wren -> if_id_instr=32'h00500093, if_id_pc=0.
REQ-034 imem_ready held low 3 cycles:
- imem_req and imem_addr stable for 4 cycles, fetch_busy=1.
- Capture on the 4th cycle.
REQ-035 wb_if_wren with pc=32'hFFFF_FFFC, branch_taken=0 -> pc=0. Then branch_taken=1, branch_target=32'h0000_1007 -> pc=32'h0000_1004.
REQ-036 stage_reset_n=0 during WAIT -> imem_req=0 and FSM=IDLE next cycle, with PC unchanged. if_id_wren after that -> if_id_instr=NOP.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ready stuck 0 -> fetch_fault=1 and instr_valid=1 after 4 WAIT cycles, and the buffered word is NOP.
REQ-038 fetch_start during WAIT and during DONE -> no extra request and no state change.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE / REQ / WAIT / DONE)
//   NOP_INSTR     : instruction word injected when no fetched word is available
//   PC_INC        : sequential PC step
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
//   Program counter register with its next-PC mux.
//   Ports:
//     clk, reset_n      : clock, synchronous active-low reset (loads RESET_PC)
//     i_wren            : PC update strobe
//     i_branch_taken    : choose i_branch_target (word aligned) over PC + 4
//     i_branch_target   : branch destination
//     o_pc              : current PC
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wren,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Sequential step wraps naturally at 2^32; branch targets are forced to
    // word alignment.
    assign w_pc_next = i_branch_taken ? {i_branch_target[31:2], 2'b00}
                                      : r_pc + PC_INC;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_pc <= RESET_PC;
        else if (i_wren)
            r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Single-outstanding instruction fetch stage with IF/ID output registers.
//   Optional macro FETCH_TIMEOUT_EN: WAIT-state watchdog that, after
//   TIMEOUT_CYCLES waiting cycles, buffers a NOP and raises sticky fetch_fault.
//   Ports:
//     clk, reset_n         : clock, synchronous active-low reset
//     stage_reset_n        : active-low abort of the in-flight fetch
//     fetch_start          : start one fetch at the current PC (IDLE only)
//     wb_if_wren           : PC update strobe (branch_taken / branch_target)
//     if_id_wren           : load if_id_instr / if_id_pc
//     imem_req, imem_addr  : instruction memory request
//     imem_ready, imem_rdata : same-cycle accept and read data
//     if_id_instr, if_id_pc  : IF/ID pipeline registers
//     instr_valid, fetch_busy, fetch_fault : status
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stage_reset_n,
    input  logic        fetch_start,
    input  logic        wb_if_wren,
    input  logic        if_id_wren,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  w_pc;
    logic [31:0]  r_buf;
    logic         w_capture;
    logic         w_timeout;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_wren          (wb_if_wren),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc            (w_pc)
    );

    assign w_capture = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && imem_ready;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_fault;

    // Fires on the WAIT cycle whose count reaches TIMEOUT_CYCLES; a word
    // arriving in that same cycle wins.
    assign w_timeout = (r_state == ST_WAIT) && !imem_ready &&
                       ((r_wait_cnt + 8'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            if (r_state != ST_WAIT)
                r_wait_cnt <= 8'd0;
            else
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign w_timeout   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state; stage abort overrides everything else
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (fetch_start) w_state_next = ST_REQ;
            ST_REQ:  w_state_next = imem_ready ? ST_DONE : ST_WAIT;
            ST_WAIT: if (imem_ready || w_timeout) w_state_next = ST_DONE;
            ST_DONE: if (if_id_wren) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (!stage_reset_n)
            w_state_next = ST_IDLE;
    end

    // Outputs decoded from state; the address tracks the live PC so a PC
    // update during an outstanding fetch is seen by memory immediately.
    always_comb begin
        imem_req    = (r_state == ST_REQ) || (r_state == ST_WAIT);
        fetch_busy  = (r_state == ST_REQ) || (r_state == ST_WAIT);
        instr_valid = (r_state == ST_DONE);
        imem_addr   = w_pc;
    end

    // Fetch buffer and IF/ID registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf       <= NOP_INSTR;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= RESET_PC;
        end else begin
            if (w_capture)
                r_buf <= imem_rdata;
            else if (w_timeout)
                r_buf <= NOP_INSTR;
            if (if_id_wren) begin
                if_id_instr <= (r_state == ST_DONE) ? r_buf : NOP_INSTR;
                if_id_pc    <= w_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stage_reset_n;
    logic        fetch_start;
    logic        wb_if_wren;
    logic        if_id_wren;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (8'd4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stage_reset_n (stage_reset_n),
        .fetch_start   (fetch_start),
        .wb_if_wren    (wb_if_wren),
        .if_id_wren    (if_id_wren),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .fetch_fault   (fetch_fault)
    );

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
    endtask

    task automatic pc_update(input logic taken, input logic [31:0] tgt);
        wb_if_wren    = 1'b1;
        branch_taken  = taken;
        branch_target = tgt;
        cyc();
        wb_if_wren    = 1'b0;
        branch_taken  = 1'b0;
    endtask

    // Load IF/ID and score it against the oldest expected entry.
    task automatic ifid_write_and_score(input string name);
        exp_t e;
        if_id_wren = 1'b1;
        cyc();
        if_id_wren = 1'b0;
        n_tot++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got instr=%h pc=%h", name, if_id_instr, if_id_pc);
        end else begin
            e = sb_q.pop_front();
            if ({if_id_instr, if_id_pc} !== {e.instr, e.pc})
                $display("FAIL %s: got instr=%h pc=%h, want instr=%h pc=%h",
                         name, if_id_instr, if_id_pc, e.instr, e.pc);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        n_tot++;
        if ({imem_req, instr_valid, fetch_busy, fetch_fault} !== 4'b0000)
            $display("FAIL reset_status: got req/valid/busy/fault=%b want 0000",
                     {imem_req, instr_valid, fetch_busy, fetch_fault});
        else n_pass++;
        n_tot++;
        if ({if_id_instr, if_id_pc, imem_addr} !== {NOP, 32'h0, 32'h0})
            $display("FAIL reset_regs: got instr=%h pc=%h addr=%h want %h 0 0",
                     if_id_instr, if_id_pc, imem_addr, NOP);
        else n_pass++;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_zero_wait();
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        pulse_start();
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid} !== 3'b110 || imem_addr !== 32'h0)
            $display("FAIL zw_req_t1: got req/busy/valid=%b addr=%h want 110 0",
                     {imem_req, fetch_busy, instr_valid}, imem_addr);
        else n_pass++;
        cyc();
        imem_ready = 1'b0;
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid} !== 3'b001)
            $display("FAIL zw_valid_t2: got req/busy/valid=%b want 001",
                     {imem_req, fetch_busy, instr_valid});
        else n_pass++;
        sb_q.push_back('{instr: 32'h0050_0093, pc: 32'h0});
        ifid_write_and_score("zw_ifid");
        n_tot++;
        if (instr_valid !== 1'b0)
            $display("FAIL zw_back_idle: got valid=%b want 0", instr_valid);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        pc_update(1'b0, 32'h0);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            n_tot++;
            if ({imem_req, fetch_busy, instr_valid} !== 3'b110 || imem_addr !== 32'h4)
                $display("FAIL wait_hold_%0d: got req/busy/valid=%b addr=%h want 110 4",
                         i, {imem_req, fetch_busy, instr_valid}, imem_addr);
            else n_pass++;
            if (i == 3) imem_ready = 1'b1;
            cyc();
        end
        imem_ready = 1'b0;
        n_tot++;
        if ({imem_req, instr_valid} !== 2'b01)
            $display("FAIL wait_capture: got req/valid=%b want 01", {imem_req, instr_valid});
        else n_pass++;
        sb_q.push_back('{instr: 32'hDEAD_BEEF, pc: 32'h4});
        ifid_write_and_score("wait_ifid");
    endtask

    task automatic test_ignore_start();
        imem_ready = 1'b0;
        imem_rdata = 32'h1234_5678;
        pulse_start();
        cyc();
        pulse_start();
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid} !== 3'b110)
            $display("FAIL ign_in_wait: got req/busy/valid=%b want 110",
                     {imem_req, fetch_busy, instr_valid});
        else n_pass++;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        pulse_start();
        cyc();
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid} !== 3'b001)
            $display("FAIL ign_in_done: got req/busy/valid=%b want 001",
                     {imem_req, fetch_busy, instr_valid});
        else n_pass++;
        sb_q.push_back('{instr: 32'h1234_5678, pc: 32'h4});
        ifid_write_and_score("ign_ifid");
    endtask

    task automatic test_pc_during_busy();
        imem_ready = 1'b0;
        imem_rdata = 32'hAAAA_5555;
        pulse_start();
        cyc();
        pc_update(1'b1, 32'h0000_0203);
        n_tot++;
        if ({imem_req, fetch_busy} !== 2'b11 || imem_addr !== 32'h0000_0200)
            $display("FAIL busy_pc_follow: got req/busy=%b addr=%h want 11 00000200",
                     {imem_req, fetch_busy}, imem_addr);
        else n_pass++;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        sb_q.push_back('{instr: 32'hAAAA_5555, pc: 32'h0000_0200});
        ifid_write_and_score("busy_pc_ifid");
    endtask

    task automatic test_pc_wrap();
        pc_update(1'b1, 32'hFFFF_FFFF);
        n_tot++;
        if (imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL pc_align_top: got %h want FFFFFFFC", imem_addr);
        else n_pass++;
        pc_update(1'b0, 32'h0);
        n_tot++;
        if (imem_addr !== 32'h0)
            $display("FAIL pc_wrap: got %h want 00000000", imem_addr);
        else n_pass++;
        pc_update(1'b1, 32'h0000_1007);
        n_tot++;
        if (imem_addr !== 32'h0000_1004)
            $display("FAIL pc_branch: got %h want 00001004", imem_addr);
        else n_pass++;
    endtask

    task automatic test_stage_reset();
        imem_ready = 1'b0;
        pulse_start();
        cyc();
        stage_reset_n = 1'b0;
        fetch_start   = 1'b1;
        cyc();
        stage_reset_n = 1'b1;
        fetch_start   = 1'b0;
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid} !== 3'b000 || imem_addr !== 32'h0000_1004)
            $display("FAIL sr_abort: got req/busy/valid=%b addr=%h want 000 00001004",
                     {imem_req, fetch_busy, instr_valid}, imem_addr);
        else n_pass++;
        n_tot++;
        if ({if_id_instr, if_id_pc} !== {32'hAAAA_5555, 32'h0000_0200})
            $display("FAIL sr_ifid_keep: got instr=%h pc=%h want AAAA5555 00000200",
                     if_id_instr, if_id_pc);
        else n_pass++;
        cyc();
        n_tot++;
        if (fetch_busy !== 1'b0)
            $display("FAIL sr_stay_idle: got busy=%b want 0", fetch_busy);
        else n_pass++;
        sb_q.push_back('{instr: NOP, pc: 32'h0000_1004});
        ifid_write_and_score("sr_nop_ifid");
    endtask

    task automatic test_timeout();
        imem_ready = 1'b0;
        imem_rdata = 32'hCAFE_F00D;
        pulse_start();
        for (int k = 0; k < 4; k++) cyc();
        n_tot++;
        if ({fetch_busy, instr_valid, fetch_fault} !== 3'b100)
            $display("FAIL to_before: got busy/valid/fault=%b want 100",
                     {fetch_busy, instr_valid, fetch_fault});
        else n_pass++;
`ifdef FETCH_TIMEOUT_EN
        cyc();
        n_tot++;
        if ({fetch_busy, instr_valid, fetch_fault} !== 3'b011)
            $display("FAIL to_fire: got busy/valid/fault=%b want 011",
                     {fetch_busy, instr_valid, fetch_fault});
        else n_pass++;
        sb_q.push_back('{instr: NOP, pc: 32'h0000_1004});
        ifid_write_and_score("to_nop_ifid");
        n_tot++;
        if (fetch_fault !== 1'b1)
            $display("FAIL to_sticky: got fault=%b want 1", fetch_fault);
        else n_pass++;
`else
        for (int k = 0; k < 20; k++) cyc();
        n_tot++;
        if ({fetch_busy, instr_valid, fetch_fault} !== 3'b100)
            $display("FAIL to_disabled: got busy/valid/fault=%b want 100",
                     {fetch_busy, instr_valid, fetch_fault});
        else n_pass++;
        stage_reset_n = 1'b0;
        cyc();
        stage_reset_n = 1'b1;
`endif
    endtask

    task automatic test_reset_mid_fetch();
        imem_ready = 1'b0;
        pulse_start();
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        n_tot++;
        if ({imem_req, fetch_busy, instr_valid, fetch_fault} !== 4'b0000 || imem_addr !== 32'h0)
            $display("FAIL rst_mid: got req/busy/valid/fault=%b addr=%h want 0000 0",
                     {imem_req, fetch_busy, instr_valid, fetch_fault}, imem_addr);
        else n_pass++;
        n_tot++;
        if ({if_id_instr, if_id_pc} !== {NOP, 32'h0})
            $display("FAIL rst_mid_ifid: got instr=%h pc=%h want %h 0", if_id_instr, if_id_pc, NOP);
        else n_pass++;
    endtask

    initial begin
        reset_n       = 1'b0;
        stage_reset_n = 1'b1;
        fetch_start   = 1'b0;
        wb_if_wren    = 1'b0;
        if_id_wren    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        #2;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_ignore_start();
        test_pc_during_busy();
        test_pc_wrap();
        test_stage_reset();
        test_timeout();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
